// File: rtl/formula_feeder_pkg.sv
// Shared types for the formula argument feeder.
package formula_feeder_pkg;

   localparam int unsigned arg_width_def = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [arg_width_def-1:0] a;
      logic [arg_width_def-1:0] b;
      logic [arg_width_def-1:0] c;
   } triple_t;

   localparam int unsigned triple_width_def = $bits(triple_t);

endpackage

// File: rtl/formula_arg_fifo.sv
// Small FIFO holding argument triples; pointers carry one wrap bit.
module formula_arg_fifo #(
   parameter int unsigned depth = 4,
   parameter int unsigned width = formula_feeder_pkg::triple_width_def
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [width-1:0] din,
   output logic [width-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned aw = $clog2(depth);
   localparam logic [aw:0] ptr_one = (aw+1)'(1);

   logic [aw:0]      wr_ptr;
   logic [aw:0]      rd_ptr;
   logic [width-1:0] mem [depth];

   // Pointer update; push/pop are ignored when full/empty respectively.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + ptr_one;
         if (pop  && !empty) rd_ptr <= rd_ptr + ptr_one;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[aw-1:0]] <= din;
   end

   // Head read and occupancy flags from pointer compare.
   always_comb begin
      dout  = mem[rd_ptr[aw-1:0]];
      empty = (wr_ptr == rd_ptr);
      full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
   end

endmodule

// File: rtl/formula_arg_feeder.sv
// Buffers argument triples and issues them one at a time to a formula top,
// waiting for each result before issuing the next.
module formula_arg_feeder
   import formula_feeder_pkg::*;
#(
   parameter int unsigned arg_width = arg_width_def,
   parameter int unsigned depth     = 4,
   parameter int unsigned timeout   = 256,
   parameter int unsigned cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [arg_width-1:0] in_a,
   input  logic [arg_width-1:0] in_b,
   input  logic [arg_width-1:0] in_c,
   output logic                 arg_vld,
   output logic [arg_width-1:0] a,
   output logic [arg_width-1:0] b,
   output logic [arg_width-1:0] c,
   input  logic                 res_vld,
   output logic                 busy,
   output logic [cnt_width-1:0] n_issued,
   output logic [cnt_width-1:0] n_done,
   output logic                 err_spurious,
   output logic                 err_timeout
);

   localparam int unsigned trip_w = 3 * arg_width;
   localparam int unsigned wait_w = $clog2(timeout);
   localparam logic [wait_w-1:0]    wait_last = wait_w'(timeout - 1);
   localparam logic [wait_w-1:0]    wait_one  = wait_w'(1);
   localparam logic [cnt_width-1:0] cnt_one   = cnt_width'(1);

   state_t                state, state_n;
   logic [wait_w-1:0]     wait_cnt, wait_cnt_n;
   logic                  arg_vld_n;
   logic [arg_width-1:0]  a_n, b_n, c_n;
   logic [cnt_width-1:0]  n_issued_n, n_done_n;
   logic                  err_spurious_n, err_timeout_n;

   logic                  fifo_full, fifo_empty, push_c, pop_c;
   logic [trip_w-1:0]     fifo_din, fifo_dout;

   assign fifo_din = {in_a, in_b, in_c};
   assign push_c   = in_vld && !fifo_full;
   assign in_rdy   = !fifo_full;
   assign busy     = !fifo_empty || (state != IDLE);

   formula_arg_fifo #(
      .depth (depth),
      .width (trip_w)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_c),
      .pop   (pop_c),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, issue and bookkeeping logic.
   always_comb begin
      state_n        = state;
      wait_cnt_n     = wait_cnt;
      arg_vld_n      = 1'b0;
      a_n            = a;
      b_n            = b;
      c_n            = c;
      n_issued_n     = n_issued;
      n_done_n       = n_done;
      err_spurious_n = err_spurious || (res_vld && (state != WAIT));
      err_timeout_n  = err_timeout;
      pop_c          = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop_c     = 1'b1;
               a_n       = fifo_dout[trip_w-1 -: arg_width];
               b_n       = fifo_dout[2*arg_width-1 -: arg_width];
               c_n       = fifo_dout[arg_width-1:0];
               arg_vld_n = 1'b1;
               state_n   = ISSUE;
            end
         end
         ISSUE: begin
            n_issued_n = n_issued + cnt_one;
            wait_cnt_n = '0;
            state_n    = WAIT;
         end
         WAIT: begin
            if (res_vld) begin
               n_done_n = n_done + cnt_one;
               state_n  = IDLE;
            end else if (wait_cnt == wait_last) begin
               err_timeout_n = 1'b1;
               state_n       = IDLE;
            end else begin
               wait_cnt_n = wait_cnt + wait_one;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         arg_vld      <= 1'b0;
         a            <= '0;
         b            <= '0;
         c            <= '0;
         n_issued     <= '0;
         n_done       <= '0;
         err_spurious <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_n;
         wait_cnt     <= wait_cnt_n;
         arg_vld      <= arg_vld_n;
         a            <= a_n;
         b            <= b_n;
         c            <= c_n;
         n_issued     <= n_issued_n;
         n_done       <= n_done_n;
         err_spurious <= err_spurious_n;
         err_timeout  <= err_timeout_n;
      end
   end

endmodule

// File: tb/tb_formula_arg_feeder.sv
// Directed bench for formula_arg_feeder (depth 4, timeout 8).
module tb_formula_arg_feeder;
   import formula_feeder_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [31:0] in_a = '0, in_b = '0, in_c = '0;
   logic        arg_vld;
   logic [31:0] a, b, c;
   logic        res_vld = 1'b0;
   logic        busy;
   logic [15:0] n_issued, n_done;
   logic        err_spurious, err_timeout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int mon_a[$];
   int mon_cyc[$];

   formula_arg_feeder #(
      .arg_width (32),
      .depth     (4),
      .timeout   (8),
      .cnt_width (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_c         (in_c),
      .arg_vld      (arg_vld),
      .a            (a),
      .b            (b),
      .c            (c),
      .res_vld      (res_vld),
      .busy         (busy),
      .n_issued     (n_issued),
      .n_done       (n_done),
      .err_spurious (err_spurious),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Issue monitor: record every arg_vld pulse and its cycle.
   always @(negedge clk) begin
      if (arg_vld) begin
         mon_a.push_back(int'(a));
         mon_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input triple_t t);
      in_vld = 1'b1;
      in_a   = t.a;
      in_b   = t.b;
      in_c   = t.c;
      tick();
      in_vld = 1'b0;
   endtask

   task automatic wait_arg(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (arg_vld) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (arg_vld !== 1'b0) begin n_err++; $display("FAIL rst_arg_vld got %0h want 0", arg_vld); end
      n_cmp++; if (a !== 32'd0) begin n_err++; $display("FAIL rst_a got %0h want 0", a); end
      n_cmp++; if (n_issued !== 16'd0) begin n_err++; $display("FAIL rst_n_issued got %0d want 0", n_issued); end
      n_cmp++; if (n_done !== 16'd0) begin n_err++; $display("FAIL rst_n_done got %0d want 0", n_done); end
      n_cmp++; if (err_spurious !== 1'b0 || err_timeout !== 1'b0) begin n_err++; $display("FAIL rst_errs got %0b%0b want 00", err_spurious, err_timeout); end
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_in_rdy got %0h want 1", in_rdy); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0h want 0", busy); end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      triple_t t;
      t = '{a: 32'd1, b: 32'd1, c: 32'd1};
      push(t);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %0h want 1", busy); end
      n_cmp++; if (arg_vld !== 1'b0) begin n_err++; $display("FAIL single_pre_arg got %0h want 0", arg_vld); end
      tick();
      n_cmp++; if (arg_vld !== 1'b1) begin n_err++; $display("FAIL single_arg_vld got %0h want 1", arg_vld); end
      n_cmp++; if ({a, b, c} !== {32'd1, 32'd1, 32'd1}) begin n_err++; $display("FAIL single_abc got %0h %0h %0h want 1 1 1", a, b, c); end
      repeat (4) tick();
      n_cmp++; if (n_issued !== 16'd1) begin n_err++; $display("FAIL single_issued_mid got %0d want 1", n_issued); end
      res_vld = 1'b1;
      tick();
      res_vld = 1'b0;
      n_cmp++; if (n_done !== 16'd1) begin n_err++; $display("FAIL single_n_done got %0d want 1", n_done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %0h want 0", busy); end
      n_cmp++; if (mon_a.size() !== 1) begin n_err++; $display("FAIL single_pulses got %0d want 1", mon_a.size()); end
      n_cmp++; if (a !== 32'd1) begin n_err++; $display("FAIL single_a_hold got %0h want 1", a); end
      n_cmp++; if (err_spurious !== 1'b0 || err_timeout !== 1'b0) begin n_err++; $display("FAIL single_errs got %0b%0b want 00", err_spurious, err_timeout); end
   endtask

   task automatic test_back_to_back();
      int base;
      base = mon_a.size();
      fork
         begin
            push('{a: 32'd0, b: 32'd100, c: 32'd200});
            push('{a: 32'd1, b: 32'd101, c: 32'd201});
            push('{a: 32'd4, b: 32'd104, c: 32'd204});
         end
         begin
            for (int i = 0; i < 3; i++) begin
               bit ok;
               wait_arg(ok);
               n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_wait_arg got none want pulse %0d", i); end
               tick();
               res_vld = 1'b1;
               tick();
               res_vld = 1'b0;
            end
         end
      join
      n_cmp++; if (mon_a.size() !== base + 3) begin n_err++; $display("FAIL b2b_pulses got %0d want %0d", mon_a.size(), base + 3); end
      if (mon_a.size() >= base + 3) begin
         n_cmp++; if (mon_a[base] !== 0 || mon_a[base+1] !== 1 || mon_a[base+2] !== 4) begin n_err++; $display("FAIL b2b_order got %0d %0d %0d want 0 1 4", mon_a[base], mon_a[base+1], mon_a[base+2]); end
         n_cmp++; if (mon_cyc[base+1] - mon_cyc[base] !== 3) begin n_err++; $display("FAIL b2b_gap1 got %0d want 3", mon_cyc[base+1] - mon_cyc[base]); end
         n_cmp++; if (mon_cyc[base+2] - mon_cyc[base+1] !== 3) begin n_err++; $display("FAIL b2b_gap2 got %0d want 3", mon_cyc[base+2] - mon_cyc[base+1]); end
      end
      n_cmp++; if (n_issued !== 16'd4 || n_done !== 16'd4) begin n_err++; $display("FAIL b2b_counts got %0d/%0d want 4/4", n_issued, n_done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy got %0h want 0", busy); end
   endtask

   task automatic test_full_timeout();
      int base;
      base = mon_a.size();
      for (int k = 1; k <= 5; k++) push('{a: 32'(10*k), b: 32'(10*k+1), c: 32'(10*k+2)});
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL full_in_rdy got %0h want 0", in_rdy); end
      n_cmp++; if (mon_a.size() !== base + 1) begin n_err++; $display("FAIL full_pulses got %0d want %0d", mon_a.size(), base + 1); end
      in_vld = 1'b1;
      in_a = 32'd60; in_b = 32'd61; in_c = 32'd62;
      tick();
      n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL full_held got %0h want 0", in_rdy); end
      tick();
      in_vld = 1'b0;
      repeat (3) tick();
      n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_early got %0h want 0", err_timeout); end
      tick();
      n_cmp++; if (err_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_set got %0h want 1", err_timeout); end
      n_cmp++; if (n_issued !== 16'd5 || n_done !== 16'd4) begin n_err++; $display("FAIL tmo_counts got %0d/%0d want 5/4", n_issued, n_done); end
      n_cmp++; if (arg_vld !== 1'b0) begin n_err++; $display("FAIL tmo_arg_idle got %0h want 0", arg_vld); end
      tick();
      n_cmp++; if (arg_vld !== 1'b1 || a !== 32'd20) begin n_err++; $display("FAIL tmo_next got vld %0h a %0d want 1 20", arg_vld, a); end
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL tmo_in_rdy got %0h want 1", in_rdy); end
      for (int i = 0; i < 4; i++) begin
         bit ok;
         wait_arg(ok);
         n_cmp++; if (!ok) begin n_err++; $display("FAIL drain_wait_arg got none want pulse %0d", i); end
         tick();
         res_vld = 1'b1;
         tick();
         res_vld = 1'b0;
      end
      n_cmp++; if (mon_a.size() !== base + 5) begin n_err++; $display("FAIL drain_pulses got %0d want %0d", mon_a.size(), base + 5); end
      if (mon_a.size() >= base + 5) begin
         n_cmp++; if (mon_a[base] !== 10 || mon_a[base+1] !== 20 || mon_a[base+2] !== 30 || mon_a[base+3] !== 40 || mon_a[base+4] !== 50) begin
            n_err++; $display("FAIL drain_order got %0d %0d %0d %0d %0d want 10 20 30 40 50", mon_a[base], mon_a[base+1], mon_a[base+2], mon_a[base+3], mon_a[base+4]);
         end
      end
      n_cmp++; if (n_issued !== 16'd9 || n_done !== 16'd8) begin n_err++; $display("FAIL drain_counts got %0d/%0d want 9/8", n_issued, n_done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL drain_busy got %0h want 0", busy); end
      n_cmp++; if (err_spurious !== 1'b0) begin n_err++; $display("FAIL drain_spurious got %0h want 0", err_spurious); end
   endtask

   task automatic test_spurious();
      res_vld = 1'b1;
      tick();
      res_vld = 1'b0;
      n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_set got %0h want 1", err_spurious); end
      n_cmp++; if (n_done !== 16'd8) begin n_err++; $display("FAIL spur_n_done got %0d want 8", n_done); end
      repeat (3) tick();
      n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_sticky got %0h want 1", err_spurious); end
      n_cmp++; if (arg_vld !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL spur_idle got vld %0h busy %0h want 0 0", arg_vld, busy); end
   endtask

   task automatic test_reset_mid_wait();
      int base;
      push('{a: 32'd100, b: 32'd101, c: 32'd102});
      push('{a: 32'd110, b: 32'd111, c: 32'd112});
      push('{a: 32'd120, b: 32'd121, c: 32'd122});
      tick();
      n_cmp++; if (a !== 32'd100 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre got a %0d busy %0h want 100 1", a, busy); end
      base = mon_a.size();
      rst = 1'b0;
      #1;
      n_cmp++; if ({a, b, c} !== 96'd0 || arg_vld !== 1'b0) begin n_err++; $display("FAIL mid_rst_out got %0h vld %0h want 0 0", {a, b, c}, arg_vld); end
      n_cmp++; if (n_issued !== 16'd0 || n_done !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", n_issued, n_done); end
      n_cmp++; if (err_spurious !== 1'b0 || err_timeout !== 1'b0) begin n_err++; $display("FAIL mid_rst_errs got %0b%0b want 00", err_spurious, err_timeout); end
      n_cmp++; if (in_rdy !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got rdy %0h busy %0h want 1 0", in_rdy, busy); end
      tick();
      tick();
      rst = 1'b1;
      repeat (5) tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_post_busy got %0h want 0", busy); end
      n_cmp++; if (mon_a.size() !== base) begin n_err++; $display("FAIL mid_post_pulses got %0d want %0d", mon_a.size(), base); end
      res_vld = 1'b1;
      tick();
      res_vld = 1'b0;
      n_cmp++; if (err_spurious !== 1'b1 || n_done !== 16'd0) begin n_err++; $display("FAIL mid_late_res got spur %0h done %0d want 1 0", err_spurious, n_done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full_timeout();
      test_spurious();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
